io_uart: RTL
============

IO_UART -- requirements
Module: io_uart

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, reset value of the baud divisor in CLK cycles per bit (100 MHz / 115200).
REQ-002 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RES  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports CS input 1 (I/O region select); RD input 1 and WR input 1 (bus strobes, qualified by CS); ADDR input 4 (byte address, bits [3:2] select the register); BE input 4 (byte enables); DATAI input 32 (write data).
REQ-005 SHALL have port DATAO  output  32  read data, combinational from ADDR.
REQ-006 SHALL have ports UART_RXD input 1 (asynchronous serial in) and UART_TXD output 1 (serial out, idle high).
REQ-007 SHALL have ports FINISH_REQ output 1 (simulation-finish request pulse) and DEBUG output 4 ({txbusy, rxvalid, ovr, ferr}).

Function
REQ-010 Register map SHALL be: word 0 STAT, word 1 DATA, word 2 DIV, word 3 CTRL.
REQ-011 STAT read SHALL return bit0 txbusy, bit1 rxvalid, bit2 ovr, bit3 ferr, other bits 0; a write with BE[0]=1 SHALL clear each of ovr and ferr whose DATAI bit is 1 (W1C).
REQ-012 DATA read SHALL return {24'h0, rxbyte}; a qualified RD to DATA SHALL clear rxvalid on the same edge.
REQ-013 A DATA write with BE[0]=1 while txbusy=0 SHALL load DATAI[7:0] and set txbusy; while txbusy=1 the write SHALL be ignored.
REQ-014 DIV read SHALL return {16'h0, div}; writes SHALL honour BE[1:0] per byte; a resulting value below 2 SHALL be stored as 2.
REQ-015 A CTRL write with BE[0]=1 and DATAI[0]=1 SHALL assert FINISH_REQ for exactly one cycle on the following cycle.
REQ-016 TX frame SHALL be 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); each bit SHALL last exactly div cycles.
REQ-017 UART_TXD SHALL go low on the cycle after the accepted DATA write; txbusy SHALL clear exactly 10*div cycles later.
REQ-018 The TX state machine SHALL have states IDLE, START, DATA(bit 0..7), and STOP, advancing when the baud counter reaches div-1.
REQ-019 UART_RXD SHALL pass through a 2-flop synchronizer before any use.
REQ-020 The RX state machine SHALL have states IDLE, START, DATA, and STOP. A low level in IDLE SHALL enter START. START SHALL recheck the line at div/2 cycles (floor), returning to IDLE if it is high. Each later sample SHALL be taken div cycles after the previous one.
REQ-021 If the stop sample is 1, the received byte SHALL load rxbyte and set rxvalid; if rxvalid is already 1, rxbyte SHALL be overwritten and ovr set.
REQ-022 If the stop sample is 0, the byte SHALL be discarded, ferr set, and RX SHALL return to IDLE only after the line reads high.
REQ-023 When RX completion and a DATA read occur in the same cycle, the read SHALL return the old byte, and rxvalid SHALL remain 1 with the new byte.
REQ-024 A DIV write during an active frame SHALL take effect at the next bit boundary; baud counters SHALL be 16 bits and wrap only via compare reset.

Reset
REQ-030 On RES=1 at a clock edge, the following SHALL hold: UART_TXD=1, txbusy=0, rxvalid=0, ovr=0, ferr=0, rxbyte=0, div=BAUD_DIV, FINISH_REQ=0, and both state machines IDLE.
REQ-031 Reset mid-frame SHALL abort the frame immediately, with no partial byte delivered.

Structure
REQ-040 Package io_uart_pkg SHALL hold the register offsets, the STAT bit positions, the TX/RX state enums, and the frame length constant 10.
REQ-041 The receiver SHALL be a sub-module io_uart_rx (synchronizer, RX FSM, baud counter), with the bus decode and TX in io_uart.

Verification
REQ-050 With div=4, a DATA write of 0x55 SHALL produce on TXD the sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles, with txbusy 1 for exactly 40 cycles.
REQ-051 With div=4 and RXD driven with 0xA3 at 4-cycle bits, after the stop bit rxvalid=1 and DATA reads 0xA3; that read SHALL clear rxvalid.
REQ-052 Two frames 0x11 then 0x22 sent without a read SHALL give rxbyte=0x22, ovr=1; a STAT write of 0x4 SHALL clear ovr.
REQ-053 An RX frame with stop bit 0 SHALL leave rxvalid=0 and set ferr=1; a 1-cycle low glitch on RXD SHALL produce no frame.
REQ-054 A DIV write of 0x0001 SHALL read back 0x0002; a CTRL write of 0x1 SHALL make FINISH_REQ high for exactly 1 cycle.
REQ-055 RES asserted at TX bit 3 SHALL force TXD=1 and txbusy=0 on the next edge, and all registers SHALL then read their reset values.

Source files
------------

// File: rtl/io_uart_pkg.sv
// Shared constants and types for the memory-mapped UART: register offsets,
// status bit positions, FSM state types and the divisor clamp helper.
package io_uart_pkg;

    // Word offsets within the 16-byte I/O window (ADDR[3:2])
    localparam logic [1:0] REG_STAT = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // STAT register bit positions
    localparam int STAT_TXBUSY  = 0;
    localparam int STAT_RXVALID = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_FERR    = 3;

    // Start + 8 data + stop
    localparam int FRAME_BITS = 10;

    // Smallest usable divisor: the receiver needs div/2 >= 1 for its start recheck
    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/io_uart_if.sv
// CPU-side register bus of the UART: select, strobes, address, byte enables
// and data in both directions.
interface io_uart_if;
    logic        CS;
    logic        RD;
    logic        WR;
    logic [3:0]  ADDR;
    logic [3:0]  BE;
    logic [31:0] DATAI;
    logic [31:0] DATAO;

    modport master (output CS, RD, WR, ADDR, BE, DATAI, input DATAO);
    modport slave  (input CS, RD, WR, ADDR, BE, DATAI, output DATAO);
endinterface

// File: rtl/io_uart_rx.sv
// UART receiver: 2-flop synchronizer, baud counter and RX FSM. Emits a
// one-cycle done or framing-error strobe; the byte is held on rx_data.
module io_uart_rx
    import io_uart_pkg::*;
(
    input  logic        CLK,
    input  logic        RES,
    input  logic        rxd,
    input  logic [15:0] div,
    output logic        rx_done,
    output logic        rx_ferr,
    output logic [7:0]  rx_data
);
    logic        sync1_reg, sync2_reg;
    rx_state_t   state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] bdiv_reg, bdiv_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic        brk_reg, brk_next;
    logic [15:0] tgt;
    logic        tick;

    // Start-bit recheck uses half a bit period, every later sample a full one
    assign tgt  = (state_reg == RX_START) ? {1'b0, bdiv_reg[15:1]} : bdiv_reg;
    assign tick = (cnt_reg == tgt - 16'd1);

    // Synchronizer; resets to the idle (high) level so reset never fakes a start
    always_ff @(posedge CLK) begin
        if (RES) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_reg <= RX_IDLE;
            cnt_reg   <= 16'd0;
            bdiv_reg  <= 16'd0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            brk_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bdiv_reg  <= bdiv_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            brk_reg   <= brk_next;
        end
    end

    // Next-state logic; the bit period is re-latched at every sample point
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bdiv_next  = bdiv_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        brk_next   = brk_reg;
        if (state_reg != RX_IDLE && !brk_reg) begin
            cnt_next = tick ? 16'd0 : cnt_reg + 16'd1;
        end
        case (state_reg)
            RX_IDLE: begin
                if (!sync2_reg) begin
                    state_next = RX_START;
                    cnt_next   = 16'd0;
                    bdiv_next  = div;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (sync2_reg) begin
                        state_next = RX_IDLE;
                    end else begin
                        state_next = RX_DATA;
                        bit_next   = 3'd0;
                        bdiv_next  = div;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    shift_next = {sync2_reg, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    bdiv_next  = div;
                    if (bit_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            default: begin
                // After a bad stop bit, park here until the line idles high
                if (brk_reg) begin
                    if (sync2_reg) begin
                        state_next = RX_IDLE;
                        brk_next   = 1'b0;
                    end
                end else if (tick) begin
                    if (sync2_reg) begin
                        state_next = RX_IDLE;
                    end else begin
                        brk_next = 1'b1;
                    end
                end
            end
        endcase
    end

    // Completion strobes at the stop-bit sample
    always_comb begin
        rx_done = 1'b0;
        rx_ferr = 1'b0;
        if (state_reg == RX_STOP && !brk_reg && tick) begin
            rx_done = sync2_reg;
            rx_ferr = !sync2_reg;
        end
    end

    assign rx_data = shift_reg;

endmodule

// File: rtl/io_uart.sv
// Memory-mapped UART: register decode (STAT/DATA/DIV/CTRL), transmitter
// FSM and the status flags fed by the io_uart_rx receiver.
module io_uart
    import io_uart_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic        CLK,
    input  logic        RES,
    io_uart_if.slave    bus,
    input  logic        UART_RXD,
    output logic        UART_TXD,
    output logic        FINISH_REQ,
    output logic [3:0]  DEBUG
);
    localparam logic [15:0] DIV_RESET = 16'(BAUD_DIV);

    logic [1:0]  reg_sel;
    logic        rd_data, wr_stat, wr_data, wr_div, wr_ctrl;
    logic [15:0] div_reg, div_merged, div_eff;
    logic [7:0]  rxbyte_reg;
    logic        rxvalid_reg, ovr_reg, ferr_reg, finish_reg;
    logic        rx_done, rx_ferr;
    logic [7:0]  rx_data;

    tx_state_t             tx_state_reg, tx_state_next;
    logic [15:0]           tx_cnt_reg, tx_cnt_next;
    logic [15:0]           tx_bdiv_reg, tx_bdiv_next;
    logic [2:0]            tx_bit_reg, tx_bit_next;
    logic [FRAME_BITS-1:0] tx_frame_reg, tx_frame_next;
    logic                  tx_tick, txbusy;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.ADDR[1:0], bus.BE[3:2], bus.DATAI[31:16]};

    // Bus decode
    assign reg_sel = bus.ADDR[3:2];
    assign rd_data = bus.CS && bus.RD && (reg_sel == REG_DATA);
    assign wr_stat = bus.CS && bus.WR && (reg_sel == REG_STAT) && bus.BE[0];
    assign wr_data = bus.CS && bus.WR && (reg_sel == REG_DATA) && bus.BE[0];
    assign wr_div  = bus.CS && bus.WR && (reg_sel == REG_DIV);
    assign wr_ctrl = bus.CS && bus.WR && (reg_sel == REG_CTRL) && bus.BE[0] && bus.DATAI[0];

    // Per-byte merge of a DIV write
    for (genvar gi = 0; gi < 2; gi++) begin : g_div_byte
        assign div_merged[gi*8 +: 8] = bus.BE[gi] ? bus.DATAI[gi*8 +: 8] : div_reg[gi*8 +: 8];
    end

    // Divisor as it will be after this edge; bit boundaries latch this value
    assign div_eff = wr_div ? clamp_div(div_merged) : div_reg;

    // Divisor and finish-request registers
    always_ff @(posedge CLK) begin
        if (RES) begin
            div_reg    <= DIV_RESET;
            finish_reg <= 1'b0;
        end else begin
            div_reg    <= div_eff;
            finish_reg <= wr_ctrl;
        end
    end

    // RX status flags; completion takes priority over read-clear and W1C
    always_ff @(posedge CLK) begin
        if (RES) begin
            rxbyte_reg  <= 8'd0;
            rxvalid_reg <= 1'b0;
            ovr_reg     <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            if (wr_stat && bus.DATAI[STAT_OVR]) ovr_reg <= 1'b0;
            if (wr_stat && bus.DATAI[STAT_FERR]) ferr_reg <= 1'b0;
            if (rd_data) rxvalid_reg <= 1'b0;
            if (rx_done) begin
                rxbyte_reg  <= rx_data;
                rxvalid_reg <= 1'b1;
                if (rxvalid_reg) ovr_reg <= 1'b1;
            end
            if (rx_ferr) ferr_reg <= 1'b1;
        end
    end

    // Read mux
    always_comb begin
        bus.DATAO = 32'h0;
        case (reg_sel)
            REG_STAT: begin
                bus.DATAO[STAT_TXBUSY]  = txbusy;
                bus.DATAO[STAT_RXVALID] = rxvalid_reg;
                bus.DATAO[STAT_OVR]     = ovr_reg;
                bus.DATAO[STAT_FERR]    = ferr_reg;
            end
            REG_DATA: bus.DATAO[7:0]  = rxbyte_reg;
            REG_DIV:  bus.DATAO[15:0] = div_reg;
            default:  bus.DATAO = 32'h0;
        endcase
    end

    assign tx_tick = (tx_cnt_reg == tx_bdiv_reg - 16'd1);

    // TX state register
    always_ff @(posedge CLK) begin
        if (RES) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= 16'd0;
            tx_bdiv_reg  <= 16'd0;
            tx_bit_reg   <= 3'd0;
            tx_frame_reg <= '1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bdiv_reg  <= tx_bdiv_next;
            tx_bit_reg   <= tx_bit_next;
            tx_frame_reg <= tx_frame_next;
        end
    end

    // TX next state; the whole frame is shifted out LSB first, one bit per period
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bdiv_next  = tx_bdiv_reg;
        tx_bit_next   = tx_bit_reg;
        tx_frame_next = tx_frame_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                if (wr_data) begin
                    tx_state_next = TX_START;
                    tx_cnt_next   = 16'd0;
                    tx_bdiv_next  = div_eff;
                    tx_frame_next = {1'b1, bus.DATAI[7:0], 1'b0};
                end
            end
            default: begin
                tx_cnt_next = tx_tick ? 16'd0 : tx_cnt_reg + 16'd1;
                if (tx_tick) begin
                    tx_frame_next = {1'b1, tx_frame_reg[FRAME_BITS-1:1]};
                    tx_bdiv_next  = div_eff;
                    case (tx_state_reg)
                        TX_START: begin
                            tx_state_next = TX_DATA;
                            tx_bit_next   = 3'd0;
                        end
                        TX_DATA: begin
                            tx_bit_next = tx_bit_reg + 3'd1;
                            if (tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
                        end
                        default: tx_state_next = TX_IDLE;
                    endcase
                end
            end
        endcase
    end

    // TX outputs
    always_comb begin
        txbusy   = (tx_state_reg != TX_IDLE);
        UART_TXD = txbusy ? tx_frame_reg[0] : 1'b1;
    end

    assign FINISH_REQ = finish_reg;
    assign DEBUG      = {txbusy, rxvalid_reg, ovr_reg, ferr_reg};

    io_uart_rx u_rx (
        .CLK     (CLK),
        .RES     (RES),
        .rxd     (UART_RXD),
        .div     (div_eff),
        .rx_done (rx_done),
        .rx_ferr (rx_ferr),
        .rx_data (rx_data)
    );

endmodule
